// File: rtl/io_scan_pkg.sv
// Shared encodings for the IN-12 / MS6205 scan scheduler: sequencer states,
// scheduler FSM states and small combinational helpers.
package io_scan_pkg;

    typedef enum logic [2:0] {
        SEQ_NONE        = 3'd0,
        SEQ_CATHODES    = 3'd1,
        SEQ_ANODES      = 3'd2,
        SEQ_KEYBOARD_WR = 3'd3,
        SEQ_MC_ADDR     = 3'd4,
        SEQ_MC_DATA     = 3'd5,
        SEQ_KEYBOARD_RD = 3'd6,
        SEQ_STOP        = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } scan_state_e;

    localparam int BUF_DEPTH = 16;
    localparam int ROW_BITS  = 6;

    function automatic logic [3:0] next_col(input logic [3:0] col, input logic [3:0] last_col);
        return (col == last_col) ? 4'd0 : col + 4'd1;
    endfunction

    // Lowest set bit wins: the downward loop leaves the smallest index last.
    function automatic logic [2:0] lowest_set(input logic [ROW_BITS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = ROW_BITS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_scan_keydet.sv
// Keyboard new-press detector: remembers the last row seen per column and
// reports the lowest newly pressed bit one cycle after each sample.
module io_scan_keydet
    import io_scan_pkg::*;
(
    input  logic                Clock_1us,
    input  logic                Rst_n,
    input  logic                sample,
    input  logic [3:0]          col,
    input  logic [ROW_BITS-1:0] row,
    output logic                key_event,
    output logic [6:0]          key_code
);

    logic [ROW_BITS-1:0] prev_q [BUF_DEPTH];
    logic [ROW_BITS-1:0] prev_d [BUF_DEPTH];
    logic                key_event_q, key_event_d;
    logic [6:0]          key_code_q, key_code_d;
    logic [ROW_BITS-1:0] fresh;

    always_comb begin
        prev_d      = prev_q;
        key_event_d = 1'b0;
        key_code_d  = key_code_q;
        fresh       = row & ~prev_q[col];
        if (sample) begin
            // Whole row is stored, so extra simultaneous presses are swallowed.
            prev_d[col] = row;
            if (fresh != '0) begin
                key_event_d = 1'b1;
                key_code_d  = {col, lowest_set(fresh)};
            end
        end
    end

    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) prev_q[i] <= '0;
            key_event_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            prev_q      <= prev_d;
            key_event_q <= key_event_d;
            key_code_q  <= key_code_d;
        end
    end

    assign key_event = key_event_q;
    assign key_code  = key_code_q;

endmodule

// File: rtl/io_scan_scheduler.sv
// Time-slots the IN-12 anode / keyboard columns, hands each slot to the
// external sequencer and collects the keyboard row it latches.
module io_scan_scheduler
    import io_scan_pkg::*;
#(
    parameter int ANODE_COUNT = 12,
    parameter int SCAN_PERIOD = 100,
    parameter int SEQ_TIMEOUT = 64
) (
    input  logic       Clock_1us,
    input  logic       Rst_n,
    input  logic       scan_en,
    input  logic [2:0] seq_state,
    output logic       seq_enable,
    output logic [3:0] anode_idx,
    output logic [3:0] cathode_code,
    output logic [3:0] ms_addr,
    output logic [7:0] ms_data,
    input  logic       digit_we,
    input  logic [3:0] digit_waddr,
    input  logic [3:0] digit_wdata,
    input  logic       ms_we,
    input  logic [3:0] ms_waddr,
    input  logic [7:0] ms_wdata,
    input  logic [5:0] kbd_row,
    output logic       key_event,
    output logic [6:0] key_code,
    output logic       seq_fault
);

    // state | meaning
    // IDLE  | waiting for a slot tick while scan_en is set
    // LOAD  | copy buffer entries for anode_idx into the output registers
    // RUN   | sequencer enabled, waiting for STOP or the slot timeout
    // DRAIN | sequencer released, waiting for it to return to NONE

    localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int TW = $clog2(SEQ_TIMEOUT + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_TC  = TW'(SEQ_TIMEOUT);
    localparam logic [3:0]    LAST_COL    = 4'(ANODE_COUNT - 1);

    scan_state_e   state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [3:0]    anode_q, anode_d;
    logic [3:0]    cathode_q, cathode_d;
    logic [3:0]    ms_addr_q, ms_addr_d;
    logic [7:0]    ms_data_q, ms_data_d;
    logic          fault_q, fault_d;
    logic          slot_tick;
    logic          row_sample;

    logic [3:0] digit_buf_q [BUF_DEPTH];
    logic [3:0] digit_buf_d [BUF_DEPTH];
    logic [7:0] ms_buf_q    [BUF_DEPTH];
    logic [7:0] ms_buf_d    [BUF_DEPTH];

    assign slot_tick = (period_q == PERIOD_LAST);

    always_comb begin
        period_d = slot_tick ? '0 : period_q + 1'b1;
    end

    // Host writes land in the buffers only; outputs see them at the next LOAD.
    always_comb begin
        digit_buf_d = digit_buf_q;
        ms_buf_d    = ms_buf_q;
        if (digit_we) digit_buf_d[digit_waddr] = digit_wdata;
        if (ms_we)    ms_buf_d[ms_waddr]       = ms_wdata;
    end

    always_comb begin
        state_d    = state_q;
        timeout_d  = timeout_q;
        anode_d    = anode_q;
        cathode_d  = cathode_q;
        ms_addr_d  = ms_addr_q;
        ms_data_d  = ms_data_q;
        fault_d    = fault_q;
        row_sample = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (slot_tick && scan_en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cathode_d = digit_buf_q[anode_q];
                ms_addr_d = anode_q;
                ms_data_d = ms_buf_q[anode_q];
                timeout_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                timeout_d = timeout_q + 1'b1;
                if (seq_state == SEQ_STOP) begin
                    row_sample = 1'b1;
                    state_d    = ST_DRAIN;
                end else if (timeout_d == TIMEOUT_TC) begin
                    fault_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (seq_state == SEQ_NONE) begin
                    anode_d = next_col(anode_q, LAST_COL);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock_1us or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            timeout_q <= '0;
            anode_q   <= '0;
            cathode_q <= 4'hF;
            ms_addr_q <= '0;
            ms_data_q <= '0;
            fault_q   <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                digit_buf_q[i] <= 4'hF;
                ms_buf_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            timeout_q   <= timeout_d;
            anode_q     <= anode_d;
            cathode_q   <= cathode_d;
            ms_addr_q   <= ms_addr_d;
            ms_data_q   <= ms_data_d;
            fault_q     <= fault_d;
            digit_buf_q <= digit_buf_d;
            ms_buf_q    <= ms_buf_d;
        end
    end

    // Decoded straight from the state flop so reset removes it without a clock.
    assign seq_enable   = (state_q == ST_RUN);
    assign anode_idx    = anode_q;
    assign cathode_code = cathode_q;
    assign ms_addr      = ms_addr_q;
    assign ms_data      = ms_data_q;
    assign seq_fault    = fault_q;

    io_scan_keydet u_keydet (
        .Clock_1us (Clock_1us),
        .Rst_n     (Rst_n),
        .sample    (row_sample),
        .col       (anode_q),
        .row       (kbd_row),
        .key_event (key_event),
        .key_code  (key_code)
    );

endmodule

// File: tb/tb_io_scan_scheduler.sv
// Directed bench for io_scan_scheduler with a simple sequencer model and a
// keyboard model that presents a row pattern on one selected column.
module tb_io_scan_scheduler;

    logic       Clock_1us = 1'b0;
    logic       Rst_n = 1'b0;
    logic       scan_en = 1'b0;
    logic [2:0] seq_state = 3'd0;
    logic       seq_enable;
    logic [3:0] anode_idx;
    logic [3:0] cathode_code;
    logic [3:0] ms_addr;
    logic [7:0] ms_data;
    logic       digit_we = 1'b0;
    logic [3:0] digit_waddr = 4'd0;
    logic [3:0] digit_wdata = 4'd0;
    logic       ms_we = 1'b0;
    logic [3:0] ms_waddr = 4'd0;
    logic [7:0] ms_wdata = 8'd0;
    logic [5:0] kbd_row = 6'd0;
    logic       key_event;
    logic [6:0] key_code;
    logic       seq_fault;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ev_cnt = 0;
    logic [6:0] last_code = 7'd0;
    bit         stop_mode = 1'b1;
    int         en_cnt = 0;
    int         kcol = 0;
    logic [5:0] kpat = 6'd0;

    io_scan_scheduler dut (
        .Clock_1us    (Clock_1us),
        .Rst_n        (Rst_n),
        .scan_en      (scan_en),
        .seq_state    (seq_state),
        .seq_enable   (seq_enable),
        .anode_idx    (anode_idx),
        .cathode_code (cathode_code),
        .ms_addr      (ms_addr),
        .ms_data      (ms_data),
        .digit_we     (digit_we),
        .digit_waddr  (digit_waddr),
        .digit_wdata  (digit_wdata),
        .ms_we        (ms_we),
        .ms_waddr     (ms_waddr),
        .ms_wdata     (ms_wdata),
        .kbd_row      (kbd_row),
        .key_event    (key_event),
        .key_code     (key_code),
        .seq_fault    (seq_fault)
    );

    always #5 Clock_1us = ~Clock_1us;

    initial forever begin
        @(posedge Clock_1us);
        cyc++;
    end

    initial forever begin
        @(negedge Clock_1us);
        if (key_event) begin
            ev_cnt++;
            last_code = key_code;
        end
    end

    // Sequencer: STOP on the 8th enabled cycle (or never), back to NONE once released.
    initial forever begin
        @(negedge Clock_1us);
        if (seq_enable) begin
            en_cnt++;
            seq_state = (stop_mode && en_cnt >= 8) ? 3'd7 : 3'd2;
        end else begin
            en_cnt = 0;
            seq_state = 3'd0;
        end
        kbd_row = (int'(anode_idx) == kcol) ? kpat : 6'd0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_en(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_1us);
            if (seq_enable === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(output bit ok);
        bit ok0;
        wait_en(1'b0, 300, ok0);
        ok = 1'b0;
        if (ok0) wait_en(1'b1, 300, ok);
    endtask

    task automatic align(output bit ok);
        bit ok1;
        wait_en(1'b1, 300, ok1);
        ok = 1'b0;
        if (ok1) wait_en(1'b0, 300, ok);
        repeat (3) @(negedge Clock_1us);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (seq_enable !== 1'b0) begin n_err++; $display("FAIL reset_seq_enable got %b want 0", seq_enable); end
        n_cmp++; if (anode_idx !== 4'd0) begin n_err++; $display("FAIL reset_anode got %0d want 0", anode_idx); end
        n_cmp++; if (cathode_code !== 4'hF) begin n_err++; $display("FAIL reset_cathode got %h want f", cathode_code); end
        n_cmp++; if (ms_addr !== 4'd0 || ms_data !== 8'd0) begin n_err++; $display("FAIL reset_ms got %h/%h want 0/00", ms_addr, ms_data); end
        n_cmp++; if (key_event !== 1'b0 || key_code !== 7'd0) begin n_err++; $display("FAIL reset_key got %b/%h want 0/00", key_event, key_code); end
        n_cmp++; if (seq_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", seq_fault); end
        @(negedge Clock_1us);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clock_1us);
        n_cmp++; if (seq_enable !== 1'b0 || cathode_code !== 4'hF) begin n_err++; $display("FAIL post_reset_idle got en=%b cat=%h want 0/f", seq_enable, cathode_code); end
    endtask

    task automatic test_scan();
        bit ok;
        int prev_cyc;
        int hi;
        int col;
        for (int i = 0; i < 16; i++) begin
            digit_we = 1'b1; digit_waddr = 4'(i); digit_wdata = (i < 12) ? 4'(i + 1) : 4'd0;
            ms_we = 1'b1; ms_waddr = 4'(i); ms_wdata = 8'(8'h40 + i);
            @(negedge Clock_1us);
        end
        digit_we = 1'b0; ms_we = 1'b0;
        scan_en = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 13; k++) begin
            col = k % 12;
            wait_rise(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL scan_rise_timeout slot %0d got none want seq_enable", k); end
            n_cmp++; if (anode_idx !== 4'(col)) begin n_err++; $display("FAIL scan_anode slot %0d got %0d want %0d", k, anode_idx, col); end
            n_cmp++; if (cathode_code !== 4'(col + 1)) begin n_err++; $display("FAIL scan_cathode slot %0d got %0d want %0d", k, cathode_code, col + 1); end
            n_cmp++; if (ms_addr !== 4'(col) || ms_data !== 8'(8'h40 + col)) begin n_err++; $display("FAIL scan_ms slot %0d got %h/%h want %h/%h", k, ms_addr, ms_data, col, 8'h40 + col); end
            if (k > 0) begin
                n_cmp++; if (cyc - prev_cyc != 100) begin n_err++; $display("FAIL scan_spacing slot %0d got %0d want 100", k, cyc - prev_cyc); end
            end
            prev_cyc = cyc;
            hi = 1;
            repeat (50) begin
                @(negedge Clock_1us);
                if (seq_enable) hi++;
            end
            n_cmp++; if (hi != 8) begin n_err++; $display("FAIL scan_run_len slot %0d got %0d want 8", k, hi); end
        end
    endtask

    task automatic test_key_single();
        bit ok;
        align(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL key1_align got timeout want slot"); end
        kcol = 3; kpat = 6'b000100; ev_cnt = 0;
        repeat (1250) @(negedge Clock_1us);
        n_cmp++; if (ev_cnt != 1) begin n_err++; $display("FAIL key1_count got %0d want 1", ev_cnt); end
        n_cmp++; if (last_code !== 7'b0011_010) begin n_err++; $display("FAIL key1_code got %b want 0011010", last_code); end
        align(ok);
        ev_cnt = 0;
        repeat (1250) @(negedge Clock_1us);
        n_cmp++; if (ev_cnt != 0) begin n_err++; $display("FAIL key1_held got %0d want 0", ev_cnt); end
    endtask

    task automatic test_key_multi();
        bit ok;
        align(ok);
        kcol = 0; kpat = 6'b101000; ev_cnt = 0;
        repeat (1250) @(negedge Clock_1us);
        n_cmp++; if (ev_cnt != 1) begin n_err++; $display("FAIL key2_count got %0d want 1", ev_cnt); end
        n_cmp++; if (last_code !== 7'b0000_011) begin n_err++; $display("FAIL key2_code got %b want 0000011", last_code); end
        align(ok);
        ev_cnt = 0;
        repeat (1250) @(negedge Clock_1us);
        n_cmp++; if (ev_cnt != 0) begin n_err++; $display("FAIL key2_suppressed got %0d want 0", ev_cnt); end
        align(ok);
        kpat = 6'b000000; ev_cnt = 0;
        repeat (1250) @(negedge Clock_1us);
        n_cmp++; if (ev_cnt != 0) begin n_err++; $display("FAIL key2_release got %0d want 0", ev_cnt); end
        align(ok);
        kpat = 6'b100000; ev_cnt = 0;
        repeat (1250) @(negedge Clock_1us);
        n_cmp++; if (ev_cnt != 1 || last_code !== 7'b0000_101) begin n_err++; $display("FAIL key2_repress got %0d/%b want 1/0000101", ev_cnt, last_code); end
        kpat = 6'b000000;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL key2_align got timeout want slot"); end
    endtask

    task automatic test_write_during_run();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 14; t++) begin
            wait_rise(ok);
            if (!ok || anode_idx == 4'd5) break;
        end
        n_cmp++; if (!ok || anode_idx !== 4'd5) begin n_err++; $display("FAIL wr_find got %0d want 5", anode_idx); end
        n_cmp++; if (cathode_code !== 4'd6) begin n_err++; $display("FAIL wr_before got %0d want 6", cathode_code); end
        digit_we = 1'b1; digit_waddr = 4'd5; digit_wdata = 4'd7;
        @(negedge Clock_1us);
        digit_we = 1'b0;
        repeat (3) @(negedge Clock_1us);
        n_cmp++; if (seq_enable !== 1'b1 || cathode_code !== 4'd6) begin n_err++; $display("FAIL wr_during_run got en=%b cat=%0d want 1/6", seq_enable, cathode_code); end
        for (int t = 0; t < 12; t++) wait_rise(ok);
        n_cmp++; if (anode_idx !== 4'd5 || cathode_code !== 4'd7) begin n_err++; $display("FAIL wr_next_load got %0d/%0d want 5/7", anode_idx, cathode_code); end
        digit_we = 1'b1; digit_waddr = 4'd5; digit_wdata = 4'd6;
        @(negedge Clock_1us);
        digit_we = 1'b0;
    endtask

    task automatic test_scan_en_off();
        bit ok;
        int hi;
        wait_rise(ok);
        n_cmp++; if (!ok || anode_idx !== 4'd6) begin n_err++; $display("FAIL off_slot got %0d want 6", anode_idx); end
        scan_en = 1'b0;
        wait_en(1'b0, 100, ok);
        repeat (5) @(negedge Clock_1us);
        n_cmp++; if (!ok || anode_idx !== 4'd7) begin n_err++; $display("FAIL off_advance got %0d want 7", anode_idx); end
        hi = 0;
        repeat (250) begin
            @(negedge Clock_1us);
            if (seq_enable) hi++;
        end
        n_cmp++; if (hi != 0 || anode_idx !== 4'd7) begin n_err++; $display("FAIL off_idle got en_cycles=%0d anode=%0d want 0/7", hi, anode_idx); end
        scan_en = 1'b1;
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        n_cmp++; if (seq_fault !== 1'b0) begin n_err++; $display("FAIL to_fault_pre got %b want 0", seq_fault); end
        stop_mode = 1'b0;
        wait_rise(ok);
        n_cmp++; if (!ok || anode_idx !== 4'd7) begin n_err++; $display("FAIL to_slot got %0d want 7", anode_idx); end
        hi = 1;
        repeat (80) begin
            @(negedge Clock_1us);
            if (seq_enable) hi++;
        end
        n_cmp++; if (hi != 64) begin n_err++; $display("FAIL to_run_len got %0d want 64", hi); end
        n_cmp++; if (seq_fault !== 1'b1) begin n_err++; $display("FAIL to_fault got %b want 1", seq_fault); end
        stop_mode = 1'b1;
        wait_rise(ok);
        n_cmp++; if (!ok || anode_idx !== 4'd8) begin n_err++; $display("FAIL to_advance got %0d want 8", anode_idx); end
        hi = 1;
        repeat (50) begin
            @(negedge Clock_1us);
            if (seq_enable) hi++;
        end
        n_cmp++; if (hi != 8 || seq_fault !== 1'b1) begin n_err++; $display("FAIL to_sticky got len=%0d fault=%b want 8/1", hi, seq_fault); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        wait_rise(ok);
        n_cmp++; if (!ok || anode_idx !== 4'd9 || seq_fault !== 1'b1) begin n_err++; $display("FAIL rst_pre got %0d/%b want 9/1", anode_idx, seq_fault); end
        repeat (2) @(negedge Clock_1us);
        #1 Rst_n = 1'b0;
        #1;
        n_cmp++; if (seq_enable !== 1'b0) begin n_err++; $display("FAIL rst_mid_enable got %b want 0", seq_enable); end
        n_cmp++; if (anode_idx !== 4'd0 || cathode_code !== 4'hF) begin n_err++; $display("FAIL rst_mid_col got %0d/%h want 0/f", anode_idx, cathode_code); end
        n_cmp++; if (ms_addr !== 4'd0 || ms_data !== 8'd0) begin n_err++; $display("FAIL rst_mid_ms got %h/%h want 0/00", ms_addr, ms_data); end
        n_cmp++; if (key_event !== 1'b0 || key_code !== 7'd0 || seq_fault !== 1'b0) begin n_err++; $display("FAIL rst_mid_key got %b/%h/%b want 0/00/0", key_event, key_code, seq_fault); end
        @(negedge Clock_1us);
        Rst_n = 1'b1;
        wait_rise(ok);
        n_cmp++; if (!ok || anode_idx !== 4'd0) begin n_err++; $display("FAIL rst_restart_col got %0d want 0", anode_idx); end
        n_cmp++; if (cathode_code !== 4'hF || ms_data !== 8'd0) begin n_err++; $display("FAIL rst_restart_buf got %h/%h want f/00", cathode_code, ms_data); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_key_single();
        test_key_multi();
        test_write_during_run();
        test_scan_en_off();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
